// File: rtl/chacha_pkg.sv
// chacha_pkg
// Shared definitions for the ChaCha keystream core.
//   CHACHA_N_DEFAULT : default state word width in bits
//   CHACHA_C0..C3    : the four constant words ("expand 32-byte k") that
//                      occupy state words 0..3
//   chacha_state_t   : control FSM encoding used by chacha_core
package chacha_pkg;

  localparam int CHACHA_N_DEFAULT = 32;

  localparam logic [31:0] CHACHA_C0 = 32'h61707865;
  localparam logic [31:0] CHACHA_C1 = 32'h3320646e;
  localparam logic [31:0] CHACHA_C2 = 32'h79622d32;
  localparam logic [31:0] CHACHA_C3 = 32'h6b206574;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2,
    OUT  = 2'd3
  } chacha_state_t;

endpackage

// File: rtl/chacha_block.sv
// chacha_block
// One ChaCha double round (four column quarter rounds followed by four
// diagonal quarter rounds) followed by a DR_LAT-deep register pipeline.
// The result for a given in_state appears on out_state DR_LAT enabled
// clock edges after in_state was presented.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset, clears the pipeline
//   clk_en    : advances the pipeline when high
//   in_state  : 16 words of N bits, word i at [i*N +: N]
//   out_state : double-rounded state, same packing
module chacha_block
  import chacha_pkg::*;
#(
  parameter int N      = CHACHA_N_DEFAULT,
  parameter int DR_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [16*N-1:0]   in_state,
  output logic [16*N-1:0]   out_state
);

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int r);
    rotl = (x << r) | (x >> (N - r));
  endfunction

  // Returns the updated words packed as {d, c, b, a} so callers can scatter
  // them back with a single concatenation.
  function automatic logic [4*N-1:0] quarter(input logic [N-1:0] a_i,
                                             input logic [N-1:0] b_i,
                                             input logic [N-1:0] c_i,
                                             input logic [N-1:0] d_i);
    logic [N-1:0] a, b, c, d;
    a = a_i;
    b = b_i;
    c = c_i;
    d = d_i;
    a = a + b;
    d = rotl(d ^ a, 16);
    c = c + d;
    b = rotl(b ^ c, 12);
    a = a + b;
    d = rotl(d ^ a, 8);
    c = c + d;
    b = rotl(b ^ c, 7);
    quarter = {d, c, b, a};
  endfunction

  function automatic logic [16*N-1:0] double_round(input logic [16*N-1:0] s);
    logic [N-1:0]    w [16];
    logic [16*N-1:0] r;
    for (int i = 0; i < 16; i++) w[i] = s[i*N +: N];
    {w[12], w[8],  w[4], w[0]} = quarter(w[0], w[4], w[8],  w[12]);
    {w[13], w[9],  w[5], w[1]} = quarter(w[1], w[5], w[9],  w[13]);
    {w[14], w[10], w[6], w[2]} = quarter(w[2], w[6], w[10], w[14]);
    {w[15], w[11], w[7], w[3]} = quarter(w[3], w[7], w[11], w[15]);
    {w[15], w[10], w[5], w[0]} = quarter(w[0], w[5], w[10], w[15]);
    {w[12], w[11], w[6], w[1]} = quarter(w[1], w[6], w[11], w[12]);
    {w[13], w[8],  w[7], w[2]} = quarter(w[2], w[7], w[8],  w[13]);
    {w[14], w[9],  w[4], w[3]} = quarter(w[3], w[4], w[9],  w[14]);
    for (int i = 0; i < 16; i++) r[i*N +: N] = w[i];
    return r;
  endfunction

  logic [16*N-1:0] dr_value;
  logic [16*N-1:0] pipe [DR_LAT];

  assign dr_value = double_round(in_state);

  // The round logic is purely combinational; the pipeline registers behind
  // it let the round be retimed across DR_LAT stages by synthesis.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DR_LAT; i++) pipe[i] <= '0;
    end else if (clk_en) begin
      pipe[0] <= dr_value;
      for (int i = 1; i < DR_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_state = pipe[DR_LAT-1];

endmodule

// File: rtl/chacha_core.sv
// chacha_core
// Iterative ChaCha keystream generator. A request (key, 64-bit-style block
// counter, nonce, block count) produces nblocks consecutive keystream
// blocks, each presented on a valid/ready output until accepted.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   in_valid / in_ready  : request handshake (ready only while idle)
//   in_key               : 8 words, word k at [k*N +: N] -> state words 4..11
//   in_counter           : 2 words -> state words 12..13
//   in_nonce             : 2 words -> state words 14..15
//   in_nblocks           : number of blocks to produce, 0 means 1
//   out_valid / out_ready: output block handshake
//   out_data             : 16-word keystream block, word i at [i*N +: N]
//   out_last             : marks the final block of a request
module chacha_core
  import chacha_pkg::*;
#(
  parameter int N      = CHACHA_N_DEFAULT,
  parameter int ROUNDS = 20,
  parameter int DR_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*N-1:0]    in_key,
  input  logic [2*N-1:0]    in_counter,
  input  logic [2*N-1:0]    in_nonce,
  input  logic [7:0]        in_nblocks,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*N-1:0]   out_data,
  output logic              out_last
);

  localparam int DR_TOTAL = ROUNDS / 2;
  localparam int DR_W     = $clog2(DR_TOTAL + 1);
  localparam int LAT_W    = $clog2(DR_LAT + 1);

  localparam logic [DR_W-1:0]  DR_FINAL    = DR_W'(DR_TOTAL - 1);
  localparam logic [LAT_W-1:0] LAT_CAPTURE = LAT_W'(DR_LAT);

  function automatic logic [16*N-1:0] build_state(input logic [8*N-1:0] key,
                                                  input logic [2*N-1:0] ctr,
                                                  input logic [2*N-1:0] nonce);
    build_state = {nonce, ctr, key,
                   N'(CHACHA_C3), N'(CHACHA_C2), N'(CHACHA_C1), N'(CHACHA_C0)};
  endfunction

  chacha_state_t     state;
  logic [8*N-1:0]    key_q;
  logic [2*N-1:0]    counter_q;
  logic [2*N-1:0]    nonce_q;
  logic [7:0]        blk_cnt;
  logic [DR_W-1:0]   dr_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [16*N-1:0]   working;
  logic [16*N-1:0]   init_state;
  logic [16*N-1:0]   blk_in;
  logic [16*N-1:0]   blk_out;
  logic [2*N-1:0]    counter_next;
  logic [16*N-1:0]   accept_state;
  logic [16*N-1:0]   reload_state;

  // Ready is gated by reset so it reads 0 while reset is held and rises the
  // moment reset drops, with the FSM already parked in IDLE.
  assign in_ready     = (state == IDLE) && !reset;
  assign counter_next = counter_q + (2*N)'(1);
  assign accept_state = build_state(in_key, in_counter, in_nonce);
  assign reload_state = build_state(key_q, counter_next, nonce_q);

  // On the cycle a round result is captured, that result is also fed straight
  // back into the stage so the next round starts without waiting a cycle for
  // the working register; this keeps one round per DR_LAT cycles.
  assign blk_in = (lat_cnt == LAT_CAPTURE) ? blk_out : working;

  chacha_block #(
    .N      (N),
    .DR_LAT (DR_LAT)
  ) u_block (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (1'b1),
    .in_state  (blk_in),
    .out_state (blk_out)
  );

  // Control FSM. IDLE accepts a request and seeds both state registers, RUN
  // iterates the double round, ADD forms the keystream block, and OUT holds
  // it until the consumer takes it, then either reloads for the next counter
  // value or returns to IDLE. Reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      key_q      <= '0;
      counter_q  <= '0;
      nonce_q    <= '0;
      blk_cnt    <= '0;
      dr_cnt     <= '0;
      lat_cnt    <= '0;
      working    <= '0;
      init_state <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            key_q      <= in_key;
            counter_q  <= in_counter;
            nonce_q    <= in_nonce;
            blk_cnt    <= (in_nblocks == 8'd0) ? 8'd1 : in_nblocks;
            working    <= accept_state;
            init_state <= accept_state;
            dr_cnt     <= '0;
            lat_cnt    <= '0;
            state      <= RUN;
          end
        end

        RUN: begin
          if (lat_cnt == LAT_CAPTURE) begin
            working <= blk_out;
            if (dr_cnt == DR_FINAL) begin
              dr_cnt  <= '0;
              lat_cnt <= '0;
              state   <= ADD;
            end else begin
              dr_cnt  <= dr_cnt + 1'b1;
              lat_cnt <= LAT_W'(1);
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        ADD: begin
          for (int i = 0; i < 16; i++) begin
            out_data[i*N +: N] <= working[i*N +: N] + init_state[i*N +: N];
          end
          out_last  <= (blk_cnt == 8'd1);
          out_valid <= 1'b1;
          state     <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (blk_cnt == 8'd1) begin
              blk_cnt <= '0;
              state   <= IDLE;
            end else begin
              blk_cnt    <= blk_cnt - 8'd1;
              counter_q  <= counter_next;
              working    <= reload_state;
              init_state <= reload_state;
              dr_cnt     <= '0;
              lat_cnt    <= '0;
              state      <= RUN;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
